// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: moves dout one bit position per clock for
// 'amount' cycles, with a start/busy/done handshake toward the sequencer.
//
// state | meaning
// IDLE  | waiting for start; dout/carry hold the last result
// SHIFT | one 1-bit shift per edge, counter counts down to 1
// DONE  | result valid, done=1 for this single cycle
module seq_shift_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] amount,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             carry,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [2:0] MODE_LSL = 3'b000;
   localparam logic [2:0] MODE_LSR = 3'b001;
   localparam logic [2:0] MODE_ASR = 3'b010;
   localparam logic [2:0] MODE_ROL = 3'b011;
   localparam logic [2:0] MODE_ROR = 3'b100;

   state_t           state;
   logic [2:0]       mode_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] shift_nxt;
   logic             shift_out;
   logic             start_reserved;
   logic             start_passthru;

   assign start_reserved = (mode > MODE_ROR);
   assign start_passthru = (amount == '0) || start_reserved;

   // One-position shift of the working register according to the latched mode.
   always_comb begin
      shift_nxt = dout;
      shift_out = carry;
      case (mode_q)
         MODE_LSL: begin
            shift_nxt = {dout[WIDTH-2:0], 1'b0};
            shift_out = dout[WIDTH-1];
         end
         MODE_LSR: begin
            shift_nxt = {1'b0, dout[WIDTH-1:1]};
            shift_out = dout[0];
         end
         MODE_ASR: begin
            shift_nxt = {dout[WIDTH-1], dout[WIDTH-1:1]};
            shift_out = dout[0];
         end
         MODE_ROL: begin
            shift_nxt = {dout[WIDTH-2:0], dout[WIDTH-1]};
            shift_out = dout[WIDTH-1];
         end
         MODE_ROR: begin
            shift_nxt = {dout[0], dout[WIDTH-1:1]};
            shift_out = dout[0];
         end
         default: begin
            shift_nxt = dout;
            shift_out = carry;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         mode_q <= MODE_LSL;
         cnt_q  <= '0;
         dout   <= '0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dout   <= din;
                  carry  <= 1'b0;
                  mode_q <= mode;
                  cnt_q  <= amount;
                  busy   <= 1'b1;
                  if (start_passthru) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SHIFT;
                     done  <= 1'b0;
                  end
               end
            end
            SHIFT: begin
               dout  <= shift_nxt;
               carry <= shift_out;
               // Counter parks at 1 on the final shift so it can never wrap.
               if (cnt_q == CNT_W'(1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: expected results are queued at start
// and checked when done is observed.
module tb_seq_shift_unit;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] mode;
   logic [3:0] amount;
   logic [7:0] din;
   logic [7:0] dout;
   logic       carry;
   logic       busy;
   logic       done;

   int tests;
   int fails;

   typedef struct {
      logic [7:0] d;
      logic       c;
      int         lat;
   } exp_t;

   exp_t sb[$];

   seq_shift_unit #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .mode(mode),
      .amount(amount),
      .din(din),
      .dout(dout),
      .carry(carry),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Iterative reference model of one full operation.
   task automatic model(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                        output logic [7:0] r, output logic c, output int lat);
      r   = d;
      c   = 1'b0;
      lat = (m > 3'd4) ? 0 : int'(a);
      for (int i = 0; i < lat; i++) begin
         case (m)
            3'd0: begin c = r[7]; r = r << 1; end
            3'd1: begin c = r[0]; r = r >> 1; end
            3'd2: begin c = r[0]; r = {r[7], r[7:1]}; end
            3'd3: begin c = r[7]; r = {r[6:0], r[7]}; end
            default: begin c = r[0]; r = {r[0], r[7:1]}; end
         endcase
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] m, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] ed, input logic ec,
                         input int lat, input bit inject);
      exp_t e;
      int   n;
      int   busy_cnt;
      e.d = ed;
      e.c = ec;
      e.lat = lat;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1; mode = m; amount = a; din = d;
      @(posedge clk);
      #1;
      // Scramble operands after the accept edge; they must not matter.
      start = 1'b0; din = ~d; amount = a + 4'd3; mode = 3'd0;
      n = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && n < 40) begin
         if (busy === 1'b1) busy_cnt++;
         if (inject && n == 2) begin
            start = 1'b1; din = 8'hFF; mode = 3'd0; amount = 4'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      e = sb.pop_front();
      chk({tag, "_timeout"}, 32'(n < 40), 32'd1);
      chk({tag, "_dout"}, 32'(dout), 32'(e.d));
      chk({tag, "_carry"}, 32'(carry), 32'(e.c));
      chk({tag, "_latency"}, 32'(n), 32'(e.lat));
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat + 1));
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
      chk({tag, "_hold"}, 32'({carry, dout}), 32'({e.c, e.d}));
   endtask

   initial begin
      logic [7:0] r;
      logic       c;
      int         lat;
      logic [2:0] rm;
      logic [3:0] ra;
      logic [7:0] rd;
      tests = 0;
      fails = 0;
      rst = 1'b1; start = 1'b0; mode = 3'd0; amount = 4'd0; din = 8'd0;
      #12;
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_carry", 32'(carry), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("lsl1", 3'd0, 4'd1, 8'h96, 8'h2C, 1'b1, 1, 1'b0);
      run_op("asr3", 3'd2, 4'd3, 8'h90, 8'hF2, 1'b0, 3, 1'b0);
      run_op("asr1", 3'd2, 4'd1, 8'h81, 8'hC0, 1'b1, 1, 1'b0);
      run_op("ror9", 3'd4, 4'd9, 8'h81, 8'hC0, 1'b1, 9, 1'b0);
      run_op("lsr0", 3'd1, 4'd0, 8'h5A, 8'h5A, 1'b0, 0, 1'b0);
      run_op("rsv6", 3'd6, 4'd5, 8'h5A, 8'h5A, 1'b0, 0, 1'b0);
      run_op("lsr15", 3'd1, 4'd15, 8'h01, 8'h00, 1'b0, 15, 1'b1);
      run_op("asr12", 3'd2, 4'd12, 8'hA5, 8'hFF, 1'b1, 12, 1'b0);
      run_op("rol11", 3'd3, 4'd11, 8'h81, 8'h0C, 1'b0, 11, 1'b0);

      // Asynchronous reset in the middle of a rotate.
      @(negedge clk);
      start = 1'b1; mode = 3'd3; amount = 4'd6; din = 8'h80;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_dout", 32'(dout), 32'd0);
      chk("arst_carry", 32'(carry), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("rol1", 3'd3, 4'd1, 8'h80, 8'h01, 1'b1, 1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         rm = 3'($urandom_range(0, 7));
         ra = 4'($urandom_range(0, 15));
         rd = 8'($urandom);
         model(rm, ra, rd, r, c, lat);
         run_op($sformatf("rnd%0d", i), rm, ra, rd, r, c, lat, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Multi-cycle, parametrised shift/rotate unit that moves one bit position per clock.
Replaces the single-position left/right shifter mux stage in the datapath.
Adds a shift amount, five modes, a carry flag and a start/busy/done handshake for the control sequencer.
Datapath width is a parameter.

Parameters:
WIDTH, 8, data width in bits (>= 2)
CNT_W, 4, shift-amount width; maximum amount is 2^CNT_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only while busy=0
mode  input  3  operation, sampled with start
amount  input  CNT_W  number of one-bit shifts, sampled with start
din  input  WIDTH  operand, sampled with start
dout  output  WIDTH  working/result register
carry  output  1  last bit shifted or rotated out
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (async, rst=1): state=IDLE; dout=0, carry=0, busy=0, done=0. Applies immediately, also mid-operation. Any in-flight operation is discarded. The first rising edge after rst falls may accept start.
- Mode encoding:
  - 000 LSL: zero fill at bit 0.
  - 001 LSR: zero fill at MSB.
  - 010 ASR: MSB replicated.
  - 011 ROL.
  - 100 ROR.
  - 101-111 reserved: treated as amount=0 (pass-through).
- States:
  - IDLE: on an edge with start=1:
    - dout <= din; carry <= 0.
    - Latch mode and amount into internal registers.
    - If amount=0 or mode is reserved -> DONE; otherwise -> SHIFT.
  - SHIFT: each edge performs one 1-bit shift of dout per mode and decrements the counter.
    - carry <= outgoing bit: MSB for LSL/ROL, LSB for LSR/ASR/ROR.
    - On the edge performing the final shift (counter=1) -> DONE.
  - DONE: done=1 for exactly this one cycle; next edge -> IDLE.
- Outputs: busy=1 in SHIFT and DONE; done is a registered state decode.
- Latency: with the accept edge T0 and amount k>0, shifts occur at edges T1..Tk. done is high between Tk and Tk+1; busy is high from T0 to Tk+1. With k=0, done is high between T0 and T1.
- dout changes during SHIFT and is only meaningful while done=1 or later in IDLE. dout and carry hold their values in IDLE until the next accepted start.
- start while busy=1 is ignored entirely: no latch, no restart, no queueing. Inputs are sampled only at the accept edge; later changes to mode, amount or din have no effect.
- Amount >= WIDTH is legal and still costs k cycles:
  - LSL/LSR -> 0.
  - ASR -> all bits equal the original MSB.
  - Rotates -> net effect is amount mod WIDTH.
  - carry always reflects the bit moved on the final shift.
- Counter is CNT_W bits and never wraps: it is loaded only in IDLE and stops at 1.

Test Plan:
1. WIDTH=8, LSL, din=0x96, amount=1 -> done one cycle after T1; dout=0x2C, carry=1; busy high for 2 cycles.
2. ASR, din=0x90, amount=3 -> dout=0xF2, carry=0, done 3 cycles after accept; then ASR din=0x81, amount=1 -> dout=0xC0, carry=1.
3. ROR, din=0x81, amount=9 -> dout=0xC0, carry=1; busy high for exactly 10 cycles; single-cycle done pulse.
4. LSR, din=0x5A, amount=0 -> done in the cycle after accept, dout=0x5A, carry=0; repeat with mode=110, amount=5 -> identical response.
5. LSR, din=0x01, amount=15 -> dout=0x00, carry=0. While busy, pulse start with din=0xFF, mode=LSL -> ignored; result unchanged.
6. ROL, din=0x80, amount=6; assert rst after the 2nd shift:
   - dout/carry/busy/done go to 0 without waiting for a clock edge.
   - After release, start ROL din=0x80, amount=1 -> dout=0x01, carry=1.
